bus_sequencer: RTL and testbench

BUS_SEQUENCER -- requirements
Module: bus_sequencer

---
 rtl/seq_pkg.sv | 52 +++++
 rtl/bus_sequencer_chk.sv | 53 +++++
 rtl/opcode_decode.sv | 19 +
 rtl/bus_sequencer.sv | 169 ++++++++++++++++
 tb/tb_bus_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the bus sequencer: state encoding, register-file
// index map, opcode values and a one-hot strobe helper.
package seq_pkg;

    // Width of the internal strobe vector; one bit per addressable register.
    localparam int unsigned NUM_IDX = 25;

    // Register-file / bus-source index map.
    localparam logic [4:0] PC_IDX   = 5'd16;
    localparam logic [4:0] IR_IDX   = 5'd17;
    localparam logic [4:0] RY_IDX   = 5'd18;
    localparam logic [4:0] RZLO_IDX = 5'd19;
    localparam logic [4:0] RZHI_IDX = 5'd20;
    localparam logic [4:0] MAR_IDX  = 5'd21;
    localparam logic [4:0] HI_IDX   = 5'd22;
    localparam logic [4:0] LO_IDX   = 5'd23;
    localparam logic [4:0] MDR_IDX  = 5'd24;

    // Supported opcodes; every other value is illegal.
    localparam logic [4:0] OP_ADD = 5'd3;
    localparam logic [4:0] OP_SUB = 5'd4;
    localparam logic [4:0] OP_AND = 5'd5;
    localparam logic [4:0] OP_OR  = 5'd6;
    localparam logic [4:0] OP_SHR = 5'd7;
    localparam logic [4:0] OP_SHL = 5'd8;
    localparam logic [4:0] OP_MUL = 5'd14;
    localparam logic [4:0] OP_DIV = 5'd15;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        CLS_SINGLE  = 2'd0,
        CLS_DOUBLE  = 2'd1,
        CLS_ILLEGAL = 2'd2
    } op_class_e;

    // One-hot load strobe for a register index.
    function automatic logic [NUM_IDX-1:0] idx_bit(input logic [4:0] idx);
        idx_bit = {{(NUM_IDX-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/bus_sequencer_chk.sv
// Protocol checker for bus_sequencer: infers the active state from the bus
// source and confirms only that state's load strobes and controls appear.
module bus_sequencer_chk
    import seq_pkg::*;
(
    input logic               clk_i,
    input logic               rst_n_i,
    input logic [NUM_IDX-1:0] load_enable_i,
    input logic [4:0]         bus_sel_i,
    input logic               bus_sel_valid_i,
    input logic               inc_pc_i,
    input logic               mem_read_i,
    input logic [4:0]         alu_op_i,
    input logic               done_i
);

    logic [NUM_IDX-1:0] allowed_s;

    // Set of strobes permitted for the state implied by the bus source.
    always_comb begin
        allowed_s = '0;
        if (!bus_sel_valid_i) begin
            allowed_s = '0;
        end else begin
            case (bus_sel_i)
                PC_IDX:   allowed_s = idx_bit(MAR_IDX) | idx_bit(RZLO_IDX);
                RZLO_IDX: begin
                    if (mem_read_i) allowed_s = idx_bit(PC_IDX) | idx_bit(MDR_IDX);
                    else            allowed_s = {{(NUM_IDX-16){1'b0}}, 16'hFFFF} | idx_bit(LO_IDX);
                end
                RZHI_IDX: allowed_s = idx_bit(HI_IDX);
                MDR_IDX:  allowed_s = idx_bit(IR_IDX);
                default: begin
                    if (bus_sel_i < PC_IDX) allowed_s = idx_bit(RY_IDX) | idx_bit(RZLO_IDX) | idx_bit(RZHI_IDX);
                    else                    allowed_s = '0;
                end
            endcase
        end
    end

    // Per-cycle protocol assertions, sampled on the active edge outside reset.
    always @(posedge clk_i) begin
        if (rst_n_i) begin
            assert ((load_enable_i & ~allowed_s) == '0)
                else $error("bus_sequencer: load strobe %h not allowed for bus source %0d", load_enable_i, bus_sel_i);
            assert (bus_sel_valid_i || (bus_sel_i == 5'd0 && !inc_pc_i && !mem_read_i && !done_i && alu_op_i == 5'd0))
                else $error("bus_sequencer: control active while bus idle");
            assert (!inc_pc_i || (bus_sel_valid_i && bus_sel_i == PC_IDX))
                else $error("bus_sequencer: incPC without pc on bus");
        end
    end

endmodule

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: single-result ALU ops write one register,
// mul/div write HI/LO, everything else is illegal.
module opcode_decode
    import seq_pkg::*;
(
    input  logic [4:0] opcode_i,
    output op_class_e  op_class_o
);

    // Classify the opcode field.
    always_comb begin
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: op_class_o = CLS_SINGLE;
            OP_MUL, OP_DIV:                                op_class_o = CLS_DOUBLE;
            default:                                       op_class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/bus_sequencer.sv
// Instruction fetch/execute sequencer driving bus source select, register load
// strobes and ALU control. Outputs are decoded from the current state and the
// IR fields: IR is reloaded on the T2 edge and memReady must gate the MDR
// strobe in the same cycle, so neither can be pre-registered one cycle early.
module bus_sequencer
    import seq_pkg::*;
#(
    parameter int BITS      = 32,
    parameter int REGISTERS = 25
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 run,
    input  logic [BITS-1:0]      ir,
    input  logic                 memReady,
    output logic [REGISTERS-1:0] loadEnable,
    output logic [4:0]           busSel,
    output logic                 busSelValid,
    output logic                 incPC,
    output logic                 memRead,
    output logic [4:0]           aluOp,
    output logic                 done,
    output logic                 illegal
);

    state_e             state_q, state_d;
    logic               illegal_q, illegal_d;

    logic [4:0]         opcode_s;
    logic [3:0]         ra_s, rb_s, rc_s;
    op_class_e          op_cls_s;

    logic [NUM_IDX-1:0] le_s;
    logic [4:0]         bus_sel_s;
    logic               bus_valid_s;
    logic               inc_pc_s;
    logic               mem_read_s;
    logic [4:0]         alu_op_s;
    logic               done_s;
    logic               unused_ir_s;

    assign opcode_s    = ir[31:27];
    assign ra_s        = ir[26:23];
    assign rb_s        = ir[22:19];
    assign rc_s        = ir[18:15];
    assign unused_ir_s = ^ir[14:0];

    opcode_decode u_decode (
        .opcode_i   (opcode_s),
        .op_class_o (op_cls_s)
    );

    // State register and sticky illegal flag; clr wipes both immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic; run is only looked at in IDLE so an instruction always completes.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_T0;
                else     state_d = ST_IDLE;
            end
            ST_T0: state_d = ST_T1;
            ST_T1: begin
                if (memReady) state_d = ST_T2;
                else          state_d = ST_T1;
            end
            ST_T2: state_d = ST_T3;
            ST_T3: begin
                if (op_cls_s == CLS_ILLEGAL) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d   = ST_T4;
                end
            end
            ST_T4: state_d = ST_T5;
            ST_T5: begin
                if (op_cls_s == CLS_DOUBLE) state_d = ST_T6;
                else                        state_d = ST_IDLE;
            end
            ST_T6:   state_d = ST_IDLE;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: exactly one bus source per active state, strobes per state table.
    always_comb begin
        le_s        = '0;
        bus_sel_s   = 5'd0;
        bus_valid_s = 1'b0;
        inc_pc_s    = 1'b0;
        mem_read_s  = 1'b0;
        alu_op_s    = 5'd0;
        done_s      = 1'b0;
        case (state_q)
            ST_T0: begin
                bus_valid_s = 1'b1;
                bus_sel_s   = PC_IDX;
                le_s        = idx_bit(MAR_IDX) | idx_bit(RZLO_IDX);
                inc_pc_s    = 1'b1;
            end
            ST_T1: begin
                bus_valid_s = 1'b1;
                bus_sel_s   = RZLO_IDX;
                mem_read_s  = 1'b1;
                if (memReady) le_s = idx_bit(PC_IDX) | idx_bit(MDR_IDX);
                else          le_s = idx_bit(PC_IDX);
            end
            ST_T2: begin
                bus_valid_s = 1'b1;
                bus_sel_s   = MDR_IDX;
                le_s        = idx_bit(IR_IDX);
            end
            ST_T3: begin
                bus_valid_s = 1'b1;
                bus_sel_s   = {1'b0, rb_s};
                if (op_cls_s == CLS_ILLEGAL) le_s = '0;
                else                         le_s = idx_bit(RY_IDX);
            end
            ST_T4: begin
                bus_valid_s = 1'b1;
                bus_sel_s   = {1'b0, rc_s};
                alu_op_s    = opcode_s;
                le_s        = idx_bit(RZLO_IDX) | idx_bit(RZHI_IDX);
            end
            ST_T5: begin
                bus_valid_s = 1'b1;
                bus_sel_s   = RZLO_IDX;
                if (op_cls_s == CLS_DOUBLE) begin
                    le_s   = idx_bit(LO_IDX);
                end else begin
                    le_s   = idx_bit({1'b0, ra_s});
                    done_s = 1'b1;
                end
            end
            ST_T6: begin
                bus_valid_s = 1'b1;
                bus_sel_s   = RZHI_IDX;
                le_s        = idx_bit(HI_IDX);
                done_s      = 1'b1;
            end
            default: begin
                le_s = '0;
            end
        endcase
    end

    assign loadEnable  = REGISTERS'(le_s);
    assign busSel      = bus_sel_s;
    assign busSelValid = bus_valid_s;
    assign incPC       = inc_pc_s;
    assign memRead     = mem_read_s;
    assign aluOp       = alu_op_s;
    assign done        = done_s;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed testbench for bus_sequencer. Inputs change on the falling edge,
// outputs are sampled 1 time unit later; expected vectors are hand-built.
module tb_bus_sequencer;
    import seq_pkg::*;

    logic        clk;
    logic        clr;
    logic        run;
    logic [31:0] ir;
    logic        memReady;
    logic [24:0] loadEnable;
    logic [4:0]  busSel;
    logic        busSelValid;
    logic        incPC;
    logic        memRead;
    logic [4:0]  aluOp;
    logic        done;
    logic        illegal;

    int checks;
    int errors;

    logic [39:0] obs_s;
    logic [39:0] e_idle, e_t0, e_t1w, e_t1r, e_t2;

    bus_sequencer #(.BITS(32), .REGISTERS(25)) dut (
        .clk         (clk),
        .clr         (clr),
        .run         (run),
        .ir          (ir),
        .memReady    (memReady),
        .loadEnable  (loadEnable),
        .busSel      (busSel),
        .busSelValid (busSelValid),
        .incPC       (incPC),
        .memRead     (memRead),
        .aluOp       (aluOp),
        .done        (done),
        .illegal     (illegal)
    );

    bus_sequencer_chk u_chk (
        .clk_i           (clk),
        .rst_n_i         (clr),
        .load_enable_i   (loadEnable),
        .bus_sel_i       (busSel),
        .bus_sel_valid_i (busSelValid),
        .inc_pc_i        (incPC),
        .mem_read_i      (memRead),
        .alu_op_i        (aluOp),
        .done_i          (done)
    );

    assign obs_s = {illegal, busSelValid, busSel, incPC, memRead, done, aluOp, loadEnable};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {illegal, valid, busSel, incPC, memRead, done, aluOp, loadEnable}
    function automatic logic [39:0] ev(input logic il, input logic v, input logic [4:0] s,
                                       input logic i, input logic r, input logic d,
                                       input logic [4:0] a, input logic [24:0] le);
        ev = {il, v, s, i, r, d, a, le};
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        mk_ir = {op, ra, rb, rc, 15'd0};
    endfunction

    task automatic test_reset();
        clr = 1'b0; run = 1'b0; memReady = 1'b0; ir = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs_s !== 40'h0) begin errors++; $display("FAIL reset_hold got %h exp %h", obs_s, 40'h0); end
        @(negedge clk); clr = 1'b1; memReady = 1'b1; #1;
        checks++;
        if (obs_s !== 40'h0) begin errors++; $display("FAIL reset_idle_mr got %h exp %h", obs_s, 40'h0); end
        @(negedge clk); memReady = 1'b0; #1;
        checks++;
        if (obs_s !== 40'h0) begin errors++; $display("FAIL reset_idle got %h exp %h", obs_s, 40'h0); end
    endtask

    task automatic test_add();
        logic [39:0] exp_v [8];
        logic        run_v [8];
        logic        mr_v  [8];
        ir    = mk_ir(OP_ADD, 4'd3, 4'd1, 4'd2);
        run_v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        mr_v  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_v = '{e_idle, e_t0, e_t1r, e_t2,
                  ev(1'b0, 1'b1, 5'd1,  1'b0, 1'b0, 1'b0, 5'd0, 25'h40000),
                  ev(1'b0, 1'b1, 5'd2,  1'b0, 1'b0, 1'b0, 5'd3, 25'h180000),
                  ev(1'b0, 1'b1, 5'd19, 1'b0, 1'b0, 1'b1, 5'd0, 25'h8),
                  e_idle};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); run = run_v[c]; memReady = mr_v[c]; #1;
            checks++;
            if (obs_s !== exp_v[c]) begin
                errors++; $display("FAIL add cyc %0d got %h exp %h", c, obs_s, exp_v[c]);
            end
        end
    endtask

    task automatic test_mul();
        logic [39:0] exp_v [9];
        logic        run_v [9];
        logic        mr_v  [9];
        ir    = mk_ir(OP_MUL, 4'd0, 4'd4, 4'd5);
        run_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        mr_v  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_v = '{e_idle, e_t0, e_t1r, e_t2,
                  ev(1'b0, 1'b1, 5'd4,  1'b0, 1'b0, 1'b0, 5'd0,  25'h40000),
                  ev(1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 5'd14, 25'h180000),
                  ev(1'b0, 1'b1, 5'd19, 1'b0, 1'b0, 1'b0, 5'd0,  25'h800000),
                  ev(1'b0, 1'b1, 5'd20, 1'b0, 1'b0, 1'b1, 5'd0,  25'h400000),
                  e_idle};
        for (int c = 0; c < 9; c++) begin
            @(negedge clk); run = run_v[c]; memReady = mr_v[c]; #1;
            checks++;
            if (obs_s !== exp_v[c]) begin
                errors++; $display("FAIL mul cyc %0d got %h exp %h", c, obs_s, exp_v[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] exp_v [15];
        logic [31:0] ir_v  [15];
        logic        run_v [15];
        logic        mr_v  [15];
        logic [31:0] i_sub;
        logic [31:0] i_and;
        i_sub = mk_ir(OP_SUB, 4'd0,  4'd7, 4'd8);
        i_and = mk_ir(OP_AND, 4'd15, 4'd9, 4'd10);
        ir_v  = '{i_sub, i_sub, i_sub, i_sub, i_sub, i_sub, i_sub,
                  i_and, i_and, i_and, i_and, i_and, i_and, i_and, i_and};
        run_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        mr_v  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_v = '{e_idle, e_t0, e_t1r, e_t2,
                  ev(1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 5'd0, 25'h40000),
                  ev(1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 5'd4, 25'h180000),
                  ev(1'b0, 1'b1, 5'd19, 1'b0, 1'b0, 1'b1, 5'd0, 25'h1),
                  e_idle, e_t0, e_t1r, e_t2,
                  ev(1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 5'd0, 25'h40000),
                  ev(1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0, 5'd5, 25'h180000),
                  ev(1'b0, 1'b1, 5'd19, 1'b0, 1'b0, 1'b1, 5'd0, 25'h8000),
                  e_idle};
        for (int c = 0; c < 15; c++) begin
            @(negedge clk); ir = ir_v[c]; run = run_v[c]; memReady = mr_v[c]; #1;
            checks++;
            if (obs_s !== exp_v[c]) begin
                errors++; $display("FAIL b2b cyc %0d got %h exp %h", c, obs_s, exp_v[c]);
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [39:0] exp_v [12];
        logic        run_v [12];
        logic        mr_v  [12];
        ir    = mk_ir(OP_OR, 4'd6, 4'd11, 4'd12);
        run_v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        mr_v  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_v = '{e_idle, e_t0, e_t1w, e_t1w, e_t1w, e_t1w, e_t1r, e_t2,
                  ev(1'b0, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, 5'd0, 25'h40000),
                  ev(1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 5'd6, 25'h180000),
                  ev(1'b0, 1'b1, 5'd19, 1'b0, 1'b0, 1'b1, 5'd0, 25'h40),
                  e_idle};
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); run = run_v[c]; memReady = mr_v[c]; #1;
            checks++;
            if (obs_s !== exp_v[c]) begin
                errors++; $display("FAIL memwait cyc %0d got %h exp %h", c, obs_s, exp_v[c]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [39:0] exp_v [7];
        logic        run_v [7];
        logic        mr_v  [7];
        logic [39:0] e_halt;
        e_halt = ev(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 25'h0);
        ir    = mk_ir(5'b11111, 4'd1, 4'd2, 4'd3);
        run_v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        mr_v  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_v = '{e_idle, e_t0, e_t1r, e_t2,
                  ev(1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 25'h0),
                  e_halt, e_halt};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk); run = run_v[c]; memReady = mr_v[c]; #1;
            checks++;
            if (obs_s !== exp_v[c]) begin
                errors++; $display("FAIL illegal cyc %0d got %h exp %h", c, obs_s, exp_v[c]);
            end
        end
        @(negedge clk); run = 1'b0; memReady = 1'b0; clr = 1'b0; #1;
        checks++;
        if (obs_s !== 40'h0) begin errors++; $display("FAIL illegal_clr got %h exp %h", obs_s, 40'h0); end
        @(negedge clk); clr = 1'b1; #1;
        checks++;
        if (obs_s !== 40'h0) begin errors++; $display("FAIL illegal_release got %h exp %h", obs_s, 40'h0); end
    endtask

    task automatic test_async_reset();
        logic [39:0] exp_a [6];
        logic        run_a [6];
        logic        mr_a  [6];
        logic [39:0] exp_b [10];
        logic        run_b [10];
        logic        mr_b  [10];
        ir    = mk_ir(OP_SHL, 4'd2, 4'd3, 4'd4);
        run_a = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        mr_a  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_a = '{e_idle, e_t0, e_t1r, e_t2,
                  ev(1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 25'h40000),
                  ev(1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 5'd8, 25'h180000)};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); run = run_a[c]; memReady = mr_a[c]; #1;
            checks++;
            if (obs_s !== exp_a[c]) begin
                errors++; $display("FAIL async_pre cyc %0d got %h exp %h", c, obs_s, exp_a[c]);
            end
        end
        // Still inside the T4 cycle, well before the next rising edge.
        #1 clr = 1'b0;
        #1;
        checks++;
        if (obs_s !== 40'h0) begin errors++; $display("FAIL async_clr got %h exp %h", obs_s, 40'h0); end
        @(negedge clk); clr = 1'b1; #1;
        checks++;
        if (obs_s !== 40'h0) begin errors++; $display("FAIL async_release got %h exp %h", obs_s, 40'h0); end
        run_b = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        mr_b  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_b = '{e_idle, e_idle, e_idle, e_t0, e_t1r, e_t2,
                  ev(1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 5'd0, 25'h40000),
                  ev(1'b0, 1'b1, 5'd4,  1'b0, 1'b0, 1'b0, 5'd8, 25'h180000),
                  ev(1'b0, 1'b1, 5'd19, 1'b0, 1'b0, 1'b1, 5'd0, 25'h4),
                  e_idle};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); run = run_b[c]; memReady = mr_b[c]; #1;
            checks++;
            if (obs_s !== exp_b[c]) begin
                errors++; $display("FAIL async_post cyc %0d got %h exp %h", c, obs_s, exp_b[c]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        e_idle = 40'h0;
        e_t0   = ev(1'b0, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 5'd0, 25'h280000);
        e_t1w  = ev(1'b0, 1'b1, 5'd19, 1'b0, 1'b1, 1'b0, 5'd0, 25'h10000);
        e_t1r  = ev(1'b0, 1'b1, 5'd19, 1'b0, 1'b1, 1'b0, 5'd0, 25'h1010000);
        e_t2   = ev(1'b0, 1'b1, 5'd24, 1'b0, 1'b0, 1'b0, 5'd0, 25'h20000);
        test_reset();
        test_add();
        test_mul();
        test_back_to_back();
        test_mem_wait();
        test_illegal();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks %0d", checks);
        $fatal(1);
    end

endmodule
